stack_queue_engine: RTL and testbench
=====================================

# stack_queue_engine

Parametrised operand store and evaluation sequencer for the stack/queue calculator, replacing the fixed 32-bit memory controller. It holds up to DEPTH operands in either LIFO or FIFO order, selected at run time. It also runs a two-operand evaluate cycle against the external combinational ALU, removing two operands and storing the result in their place. It sits between the debounced button/switch logic and the ALU/seven-segment display.

## Interface
- WIDTH, 32: operand/result width in bits.
- DEPTH, 16: capacity in entries; power of two, ≥ 2.
- OPW, 4: ALU opcode width.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset; single clock domain.
- stack_queue  in  1  mode: 1 = stack (LIFO), 0 = queue (FIFO).
- cmd_valid  in  1  command request.
- cmd  in  2  00 PUSH, 01 POP, 10 EVAL, 11 CLEAR.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- data_in  in  WIDTH  PUSH operand.
- op_in  in  OPW  EVAL opcode, captured at accept.
- alu_a, alu_b  out  WIDTH each  registered ALU operands.
- alu_op  out  OPW  registered opcode.
- alu_y  in  WIDTH  ALU result, combinational from alu_a/alu_b/alu_op.
- rsp_valid  out  1  one-cycle pulse: POP or EVAL result on rsp_data.
- rsp_data  out  WIDTH  popped value or EVAL result.
- peek  out  WIDTH  entry the next POP would return; 0 when empty.
- count  out  $clog2(DEPTH+1)  current occupancy.
- empty, full  out  1  count == 0 / count == DEPTH.
- err  out  1  illegal-command indication.

## Operation
- Storage is a circular register array with head, tail (modulo DEPTH) and count. PUSH writes at tail, then tail+1. Queue POP reads head, then head+1. Stack POP reads tail-1, then tail-1.
- FSM states: IDLE, EXEC, FLUSH. cmd_ready = (state == IDLE).
- PUSH: accepted if !full. Otherwise err, and the store is unchanged.
- POP: accepted if !empty. rsp_data ← removed entry and rsp_valid pulses. Otherwise err, and there is no rsp_valid.
- EVAL with count ≥ 2: remove two entries, register them and op_in into alu_a/alu_b/alu_op, then go to EXEC.
  - Stack: alu_b = top, alu_a = entry below top.
  - Queue: alu_a = head, alu_b = head+1.
- EVAL with count < 2: err, no state change, stay in IDLE.
- EXEC: push alu_y (cannot overflow), set rsp_data ← alu_y, pulse rsp_valid, return to IDLE.
- CLEAR: head = tail = count = 0. Storage contents are left unchanged.
- Mode change: stack_queue is registered each cycle. Any change detected while IDLE moves to FLUSH. FLUSH clears exactly as CLEAR does, then returns to IDLE. A change during EXEC is acted on after EXEC completes.
- Simultaneous events: the mode-change flush takes priority over a same-cycle command. That command is not accepted, because cmd_ready is already low.
- Arithmetic: pointers are $clog2(DEPTH) bits and wrap naturally. alu_y is truncated to WIDTH by the ALU, and this block does no arithmetic on it.

## Timing
- Reset values: state IDLE, cmd_ready 1, head/tail/count 0, empty 1, full 0, err 0, rsp_valid 0, and rsp_data/alu_a/alu_b/alu_op/peek all 0.
- Reset asserted mid-EXEC aborts the evaluation; the removed operands are lost.
- PUSH/POP/CLEAR complete in 1 cycle. count, empty, full and peek update on the accepting edge. POP's rsp_valid is high in the cycle after accept.
- EVAL has 2-cycle latency:
  - Accept edge: operands are registered and count drops by 2.
  - EXEC edge: result is pushed and count rises by 1; rsp_valid is high in the following cycle.
  - cmd_ready is low during EXEC.
- FLUSH occupies 1 cycle after the registered mode change. cmd_ready is low during it.
- err behaviour without the macro: a one-cycle pulse in the cycle after the offending accept attempt.

## Configuration
- STACK_QUEUE_ERR_STICKY_EN defined: err is sticky. It stays set until CLEAR, FLUSH or reset.
- Macro undefined: err is the one-cycle pulse described under Timing.

## Structure
- Shared package stack_queue_pkg holds:
  - command encodings CMD_PUSH, CMD_POP, CMD_EVAL, CMD_CLEAR;
  - the FSM state typedef;
  - the default WIDTH/DEPTH/OPW constants.
- One natural sub-module, sq_storage: the register array plus head/tail/count pointer logic. It provides mode-aware read ports for peek and the two EVAL operands. The FSM, error logic and ALU interface stay in the top module.

## Test plan
- Queue mode, push 5, 7, 9; POP ×3 -> rsp_data 5, 7, 9; then empty = 1 and peek = 0.
- Stack mode, push 10, 3; EVAL with subtract opcode -> alu_a = 10, alu_b = 3; with a model ALU, rsp_data = 7, count = 1, peek = 7.
- DEPTH = 4: push 1..4 -> full = 1; fifth PUSH -> err, count stays 4. Queue POP ×2 then PUSH 5, 6 -> tail wraps, and POP order is 3, 4, 5, 6.
- Single entry, EVAL -> err and count unchanged. POP on empty -> err, no rsp_valid. With STACK_QUEUE_ERR_STICKY_EN, err holds until CLEAR.
- Push 1, 2, toggle stack_queue with PUSH asserted in the same cycle -> FLUSH, count = 0, the PUSH is not accepted, and cmd_ready returns 1 in the following cycle.
- Assert rst in the EXEC cycle of an EVAL -> all outputs return to their reset values and no rsp_valid is produced.

Source files
------------

// File: rtl/stack_queue_pkg.sv
// Shared definitions for the stack/queue calculator operand store:
// command encodings, sequencer states and default sizing.
package stack_queue_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_OPW   = 4;

    localparam logic [1:0] CMD_PUSH  = 2'b00;
    localparam logic [1:0] CMD_POP   = 2'b01;
    localparam logic [1:0] CMD_EVAL  = 2'b10;
    localparam logic [1:0] CMD_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/sq_storage.sv
// Circular operand store with head/tail/count pointers and mode-aware read
// ports (peek plus the two EVAL operands) for LIFO or FIFO use.
module sq_storage
    import stack_queue_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rm_one,
    input  logic             rm_two,
    input  logic             clr,
    output logic [WIDTH-1:0] peek,
    output logic [WIDTH-1:0] opa,
    output logic [WIDTH-1:0] opb,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]    head_reg;
    logic [PW-1:0]    tail_reg;
    logic [CW-1:0]    count_reg;

    logic [PW-1:0] top_idx;
    logic [PW-1:0] below_idx;
    logic [PW-1:0] head_nxt;

    assign top_idx   = tail_reg - PW'(1);
    assign below_idx = tail_reg - PW'(2);
    assign head_nxt  = head_reg + PW'(1);

    assign count = count_reg;
    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(DEPTH));

    // Stack: top of stack sits just below tail. Queue: oldest entry at head.
    assign peek = empty ? '0 : (mode ? mem_reg[top_idx] : mem_reg[head_reg]);
    assign opa  = mode ? mem_reg[below_idx] : mem_reg[head_reg];
    assign opb  = mode ? mem_reg[top_idx]   : mem_reg[head_nxt];

    always_ff @(posedge clk) begin
        if (wr_en && !clr) begin
            mem_reg[tail_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (clr) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (wr_en) begin
            tail_reg  <= tail_reg + PW'(1);
            count_reg <= count_reg + CW'(1);
        end else if (rm_one) begin
            if (mode) tail_reg <= top_idx;
            else      head_reg <= head_nxt;
            count_reg <= count_reg - CW'(1);
        end else if (rm_two) begin
            if (mode) tail_reg <= below_idx;
            else      head_reg <= head_reg + PW'(2);
            count_reg <= count_reg - CW'(2);
        end
    end

endmodule

// File: rtl/stack_queue_engine.sv
// Operand store and two-operand evaluate sequencer for the stack/queue calculator.
// Define STACK_QUEUE_ERR_STICKY_EN to hold err until CLEAR, FLUSH or reset.
module stack_queue_engine
    import stack_queue_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int OPW   = DEF_OPW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stack_queue,
    input  logic                       cmd_valid,
    input  logic [1:0]                 cmd,
    output logic                       cmd_ready,
    input  logic [WIDTH-1:0]           data_in,
    input  logic [OPW-1:0]             op_in,
    output logic [WIDTH-1:0]           alu_a,
    output logic [WIDTH-1:0]           alu_b,
    output logic [OPW-1:0]             alu_op,
    input  logic [WIDTH-1:0]           alu_y,
    output logic                       rsp_valid,
    output logic [WIDTH-1:0]           rsp_data,
    output logic [WIDTH-1:0]           peek,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       err
);

    localparam int CW = $clog2(DEPTH + 1);

    state_t           state_reg, state_next;
    logic             mode_reg;
    logic             mode_chg;
    logic             st_push, st_pop, st_pop2, st_clr, st_bad;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] opa, opb;
    logic [WIDTH-1:0] alu_a_reg, alu_b_reg, rsp_data_reg;
    logic [OPW-1:0]   alu_op_reg;
    logic             rsp_valid_reg, err_reg;

    // mode_reg only tracks the switch while idle, so a change during EXEC
    // is still seen (and flushed) once the evaluation has finished.
    assign mode_chg  = (state_reg == ST_IDLE) && (stack_queue != mode_reg);
    assign cmd_ready = (state_reg == ST_IDLE) && !mode_chg;

    sq_storage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_storage (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode_reg),
        .wr_en   (st_push),
        .wr_data (wr_data),
        .rm_one  (st_pop),
        .rm_two  (st_pop2),
        .clr     (st_clr),
        .peek    (peek),
        .opa     (opa),
        .opb     (opb),
        .count   (count),
        .empty   (empty),
        .full    (full)
    );

    always_comb begin
        state_next = state_reg;
        st_push    = 1'b0;
        st_pop     = 1'b0;
        st_pop2    = 1'b0;
        st_clr     = 1'b0;
        st_bad     = 1'b0;
        wr_data    = data_in;
        case (state_reg)
            ST_IDLE: begin
                if (mode_chg) begin
                    state_next = ST_FLUSH;
                end else if (cmd_valid) begin
                    case (cmd)
                        CMD_PUSH: if (full)  st_bad = 1'b1; else st_push = 1'b1;
                        CMD_POP:  if (empty) st_bad = 1'b1; else st_pop  = 1'b1;
                        CMD_EVAL: begin
                            if (count < CW'(2)) begin
                                st_bad = 1'b1;
                            end else begin
                                st_pop2    = 1'b1;
                                state_next = ST_EXEC;
                            end
                        end
                        default: st_clr = 1'b1;
                    endcase
                end
            end
            ST_EXEC: begin
                st_push    = 1'b1;
                wr_data    = alu_y;
                state_next = ST_IDLE;
            end
            ST_FLUSH: begin
                st_clr     = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            mode_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE) mode_reg <= stack_queue;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            alu_op_reg    <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            err_reg       <= 1'b0;
        end else begin
            if (st_pop2) begin
                alu_a_reg  <= opa;
                alu_b_reg  <= opb;
                alu_op_reg <= op_in;
            end
            rsp_valid_reg <= st_pop || (state_reg == ST_EXEC);
            if (st_pop)                     rsp_data_reg <= peek;
            else if (state_reg == ST_EXEC)  rsp_data_reg <= alu_y;
`ifdef STACK_QUEUE_ERR_STICKY_EN
            if (st_clr)      err_reg <= 1'b0;
            else if (st_bad) err_reg <= 1'b1;
`else
            err_reg <= st_bad;
`endif
        end
    end

    assign alu_a     = alu_a_reg;
    assign alu_b     = alu_b_reg;
    assign alu_op    = alu_op_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_stack_queue_engine.sv
// Bench for stack_queue_engine: directed plan steps then random commands,
// checked against a queue-based reference model and a model ALU.
`timescale 1ns/1ps
module tb_stack_queue_engine;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int OPW   = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             stack_queue = 1'b0;
    logic             cmd_valid = 1'b0;
    logic [1:0]       cmd = 2'b00;
    logic             cmd_ready;
    logic [WIDTH-1:0] data_in = '0;
    logic [OPW-1:0]   op_in = '0;
    logic [WIDTH-1:0] alu_a, alu_b, alu_y, rsp_data, peek;
    logic [OPW-1:0]   alu_op;
    logic             rsp_valid, empty, full, err;
    logic [CW-1:0]    count;

    stack_queue_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OPW(OPW)) dut (
        .clk(clk), .rst(rst), .stack_queue(stack_queue), .cmd_valid(cmd_valid),
        .cmd(cmd), .cmd_ready(cmd_ready), .data_in(data_in), .op_in(op_in),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .peek(peek), .count(count),
        .empty(empty), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] alu_f(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [OPW-1:0] op);
        case (op)
            OPW'(0): return a + b;
            OPW'(1): return a - b;
            OPW'(2): return a & b;
            OPW'(3): return a ^ b;
            default: return a | b;
        endcase
    endfunction

    assign alu_y = alu_f(alu_a, alu_b, alu_op);

    // Reference model: m[0] is the oldest entry, m[$] the newest.
    logic [WIDTH-1:0] m[$];
    logic mode_m = 1'b0;
    logic err_m  = 1'b0;
    bit   sticky;
    int   checks = 0;
    int   errors = 0;
    int   txn = 0;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] exp_peek();
        if (m.size() == 0) return '0;
        return mode_m ? m[$] : m[0];
    endfunction

    task automatic upd_err(input bit bad, input bit clr);
        if (sticky) err_m = (err_m | bad) & ~clr;
        else        err_m = bad;
    endtask

    task automatic chk_store(input string op);
        chk({op, "_count"}, WIDTH'(count), WIDTH'(m.size()));
        chk({op, "_empty"}, WIDTH'(empty), WIDTH'(m.size() == 0));
        chk({op, "_full"},  WIDTH'(full),  WIDTH'(m.size() == DEPTH));
        chk({op, "_peek"},  peek, exp_peek());
        chk({op, "_err"},   WIDTH'(err), WIDTH'(err_m));
    endtask

    task automatic issue(input logic [1:0] c, input logic [WIDTH-1:0] d, input logic [OPW-1:0] op);
        chk("ready_at_issue", WIDTH'(cmd_ready), WIDTH'(1));
        cmd_valid = 1'b1; cmd = c; data_in = d; op_in = op;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        txn++;
    endtask

    task automatic do_push(input logic [WIDTH-1:0] d);
        bit bad;
        issue(2'b00, d, '0);
        bad = (m.size() == DEPTH);
        if (!bad) m.push_back(d);
        upd_err(bad, 1'b0);
        chk("push_rsp_valid", WIDTH'(rsp_valid), WIDTH'(0));
        chk_store("push");
        $display("txn %0d PUSH %0h mode=%0b count=%0d err=%0b", txn, d, mode_m, count, err);
    endtask

    task automatic do_pop();
        bit bad;
        logic [WIDTH-1:0] v;
        issue(2'b01, '0, '0);
        bad = (m.size() == 0);
        if (!bad) begin
            v = mode_m ? m.pop_back() : m.pop_front();
            chk("pop_rsp_valid", WIDTH'(rsp_valid), WIDTH'(1));
            chk("pop_rsp_data", rsp_data, v);
        end else begin
            chk("pop_empty_rsp_valid", WIDTH'(rsp_valid), WIDTH'(0));
        end
        upd_err(bad, 1'b0);
        chk_store("pop");
        $display("txn %0d POP mode=%0b rsp_valid=%0b rsp_data=%0h err=%0b", txn, mode_m, rsp_valid, rsp_data, err);
    endtask

    task automatic do_eval(input logic [OPW-1:0] op);
        bit bad;
        logic [WIDTH-1:0] a, b, y;
        issue(2'b10, '0, op);
        bad = (m.size() < 2);
        upd_err(bad, 1'b0);
        if (!bad) begin
            if (mode_m) begin b = m.pop_back(); a = m.pop_back(); end
            else        begin a = m.pop_front(); b = m.pop_front(); end
            chk("eval_alu_a", alu_a, a);
            chk("eval_alu_b", alu_b, b);
            chk("eval_alu_op", WIDTH'(alu_op), WIDTH'(op));
            chk("eval_exec_ready", WIDTH'(cmd_ready), WIDTH'(0));
            chk("eval_count_mid", WIDTH'(count), WIDTH'(m.size()));
            @(posedge clk); #1;
            y = alu_f(a, b, op);
            m.push_back(y);
            if (!sticky) err_m = 1'b0;
            chk("eval_rsp_valid", WIDTH'(rsp_valid), WIDTH'(1));
            chk("eval_rsp_data", rsp_data, y);
            chk("eval_ready_back", WIDTH'(cmd_ready), WIDTH'(1));
        end else begin
            chk("eval_bad_rsp_valid", WIDTH'(rsp_valid), WIDTH'(0));
            chk("eval_bad_ready", WIDTH'(cmd_ready), WIDTH'(1));
        end
        chk_store("eval");
        $display("txn %0d EVAL op=%0d mode=%0b rsp_data=%0h count=%0d err=%0b", txn, op, mode_m, rsp_data, count, err);
    endtask

    task automatic do_clear();
        issue(2'b11, '0, '0);
        m.delete();
        upd_err(1'b0, 1'b1);
        chk_store("clear");
        $display("txn %0d CLEAR count=%0d err=%0b", txn, count, err);
    endtask

    task automatic do_idle();
        @(posedge clk); #1;
        if (!sticky) err_m = 1'b0;
        chk("idle_rsp_valid", WIDTH'(rsp_valid), WIDTH'(0));
        chk_store("idle");
    endtask

    // Flip the mode switch, optionally with a PUSH presented in the same cycle.
    task automatic toggle_mode(input bit with_push, input logic [WIDTH-1:0] d);
        stack_queue = ~mode_m;
        if (with_push) begin cmd_valid = 1'b1; cmd = 2'b00; data_in = d; end
        #1;
        chk("flush_detect_ready", WIDTH'(cmd_ready), WIDTH'(0));
        @(posedge clk); #1;
        chk("flush_state_ready", WIDTH'(cmd_ready), WIDTH'(0));
        chk("flush_push_ignored", WIDTH'(count), WIDTH'(m.size()));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        txn++;
        mode_m = stack_queue;
        m.delete();
        err_m = 1'b0;
        chk("flush_ready_back", WIDTH'(cmd_ready), WIDTH'(1));
        chk_store("flush");
        $display("txn %0d MODE -> %0b push_held=%0b count=%0d", txn, mode_m, with_push, count);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"},     WIDTH'(cmd_ready), WIDTH'(1));
        chk({tag, "_count"},     WIDTH'(count), WIDTH'(0));
        chk({tag, "_empty"},     WIDTH'(empty), WIDTH'(1));
        chk({tag, "_full"},      WIDTH'(full), WIDTH'(0));
        chk({tag, "_err"},       WIDTH'(err), WIDTH'(0));
        chk({tag, "_rsp_valid"}, WIDTH'(rsp_valid), WIDTH'(0));
        chk({tag, "_rsp_data"},  rsp_data, '0);
        chk({tag, "_alu_a"},     alu_a, '0);
        chk({tag, "_alu_b"},     alu_b, '0);
        chk({tag, "_alu_op"},    WIDTH'(alu_op), WIDTH'(0));
        chk({tag, "_peek"},      peek, '0);
    endtask

    initial begin
`ifdef STACK_QUEUE_ERR_STICKY_EN
        sticky = 1'b1;
`else
        sticky = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_vals("post_reset");

        // Queue order
        do_push(5); do_push(7); do_push(9);
        do_pop(); do_pop(); do_pop();

        // Stack subtract: 10 - 3
        toggle_mode(1'b0, '0);
        do_push(10); do_push(3);
        do_eval(OPW'(1));
        do_pop();

        // Full, overflow, then queue wrap-around
        do_push(1); do_push(2); do_push(3); do_push(4);
        do_push(5);
        do_idle();
        toggle_mode(1'b0, '0);
        do_push(1); do_push(2); do_push(3); do_push(4);
        do_pop(); do_pop();
        do_push(5); do_push(6);
        do_pop(); do_pop(); do_pop(); do_pop();

        // Underflow cases and error clearing
        do_push(42);
        do_eval(OPW'(0));
        do_idle();
        do_pop();
        do_pop();
        do_idle();
        do_clear();

        // Mode change with a same-cycle PUSH
        do_push(1); do_push(2);
        toggle_mode(1'b1, 32'h77);
        toggle_mode(1'b0, '0);

        // Reset during EXEC
        do_push(20); do_push(30);
        issue(2'b10, '0, OPW'(0));
        rst = 1'b0;
        #1;
        chk_reset_vals("exec_reset");
        @(posedge clk); #1;
        chk("exec_reset_no_rsp", WIDTH'(rsp_valid), WIDTH'(0));
        rst = 1'b1;
        m.delete();
        err_m = 1'b0;
        @(posedge clk); #1;
        chk_reset_vals("exec_reset_after");
        $display("txn %0d RESET during EXEC count=%0d", txn, count);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 5)       toggle_mode(bit'($urandom_range(0, 1)), $urandom);
            else if (r < 42) do_push($urandom);
            else if (r < 65) do_pop();
            else if (r < 85) do_eval(OPW'($urandom_range(0, 7)));
            else if (r < 91) do_clear();
            else             do_idle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
